// File: rtl/brpkg.sv
// Shared definitions for the KS10 breakpoint controller: unit count and
// the console-visible state encodings.
package brpkg;

  localparam int NUNITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HALTREQ = 2'd2,
    ST_HALTED  = 2'd3
  } br_state_e;

endpackage

// File: rtl/brcsl_if.sv
// BR/CSL bus: console breakpoint registers plus the clock and reset they
// are qualified by. The br modport is the breakpoint controller's view.
interface brcsl_if;

  logic        clk;
  logic        rst;
  logic [0:35] regBRAR [0:3];
  logic [0:35] regBRMR [0:3];

  modport br (
    input clk,
    input rst,
    input regBRAR,
    input regBRMR
  );

endinterface

// File: rtl/br_unit.sv
// One breakpoint unit: masked address compare registered once, plus a
// saturating pass counter that is loaded, cleared or stepped by the controller.
module br_unit #(
  parameter int PASSW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [0:35]      addr,
  input  logic [0:35]      brar,
  input  logic [0:35]      brmr,
  input  logic             load,
  input  logic [PASSW-1:0] load_val,
  input  logic             clr,
  input  logic             step,
  output logic             hit
);

  logic             match_d;
  logic             match_q;
  logic [PASSW-1:0] cnt_q;

  // A zero mask disables the unit entirely rather than matching everything.
  assign match_d = valid && (|brmr) && ((addr & brmr) == (brar & brmr));
  assign hit     = match_q && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      match_q <= match_d;
      if (load) begin
        cnt_q <= load_val;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (step && match_q && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_ctrl.sv
// Breakpoint controller: four compare units, the arm/halt/continue FSM and
// the registered halt request to the CPU.
module br_ctrl #(
  parameter int PASSW  = 8,
  parameter int NUNITS = brpkg::NUNITS
) (
  brcsl_if.br              bus,
  input  logic             busVALID,
  input  logic [0:35]      busADDR,
  input  logic             brARM,
  input  logic [PASSW-1:0] brPASS [0:NUNITS-1],
  input  logic             cpuHALTACK,
  input  logic             brCONT,
  output logic             brHALT,
  output logic [0:NUNITS-1] brHIT,
  output logic [1:0]       brSTATE
);

  import brpkg::*;

  br_state_e           state_q, state_d;
  logic [0:NUNITS-1]   hit_q, hit_d;
  logic [0:NUNITS-1]   unit_hit;
  logic                halt_q;
  logic                load, clr_cnt, step;

  for (genvar gi = 0; gi < NUNITS; gi++) begin : g_unit
    br_unit #(.PASSW(PASSW)) u_unit (
      .clk      (bus.clk),
      .rst      (bus.rst),
      .valid    (busVALID),
      .addr     (busADDR),
      .brar     (bus.regBRAR[gi]),
      .brmr     (bus.regBRMR[gi]),
      .load     (load),
      .load_val (brPASS[gi]),
      .clr      (clr_cnt),
      .step     (step),
      .hit      (unit_hit[gi])
    );
  end

  // brARM takes priority over a coincident match or brCONT.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    load    = 1'b0;
    clr_cnt = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (brARM) begin
          load    = 1'b1;
          hit_d   = '0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (brARM) begin
          load  = 1'b1;
          hit_d = '0;
        end else begin
          step = 1'b1;
          if (|unit_hit) begin
            hit_d   = hit_q | unit_hit;
            state_d = ST_HALTREQ;
          end
        end
      end
      ST_HALTREQ: begin
        if (cpuHALTACK) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (brARM) begin
          load    = 1'b1;
          hit_d   = '0;
          state_d = ST_ARMED;
        end else if (brCONT) begin
          clr_cnt = 1'b1;
          hit_d   = '0;
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Halt request is held high for the whole HALTREQ residency: it rises with
  // entry and falls on the edge that samples cpuHALTACK (or reset).
  always_ff @(posedge bus.clk) begin
    if (bus.rst) begin
      state_q <= ST_IDLE;
      hit_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      halt_q  <= (state_d == ST_HALTREQ);
    end
  end

  assign brHALT  = halt_q;
  assign brHIT   = hit_q;
  assign brSTATE = state_q;

endmodule

// File: tb/tb_br_ctrl.sv
// Directed bench for br_ctrl: arm, pass counts, mask compare, multi-unit hits,
// halt handshake, reset during halt request and arm/match collision.
module tb_br_ctrl;

  brcsl_if bus ();

  logic        busVALID;
  logic [0:35] busADDR;
  logic        brARM;
  logic [7:0]  brPASS [0:3];
  logic        cpuHALTACK;
  logic        brCONT;
  logic        brHALT;
  logic [0:3]  brHIT;
  logic [1:0]  brSTATE;

  int vectors = 0;
  int miscompares = 0;

  br_ctrl #(.PASSW(8), .NUNITS(4)) dut (
    .bus        (bus),
    .busVALID   (busVALID),
    .busADDR    (busADDR),
    .brARM      (brARM),
    .brPASS     (brPASS),
    .cpuHALTACK (cpuHALTACK),
    .brCONT     (brCONT),
    .brHALT     (brHALT),
    .brHIT      (brHIT),
    .brSTATE    (brSTATE)
  );

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  task automatic cycle();
    @(posedge bus.clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic halt, input logic [3:0] hit);
    chk({tag, ".state"}, {6'd0, brSTATE}, {6'd0, st});
    chk({tag, ".halt"}, {7'd0, brHALT}, {7'd0, halt});
    chk({tag, ".hit"}, {4'd0, brHIT}, {4'd0, hit});
  endtask

  task automatic bus_cycle(input logic [0:35] a);
    busVALID = 1'b1;
    busADDR  = a;
    cycle();
    busVALID = 1'b0;
    busADDR  = '0;
  endtask

  task automatic pulse_arm();
    brARM = 1'b1;
    cycle();
    brARM = 1'b0;
  endtask

  task automatic pulse_ack();
    cpuHALTACK = 1'b1;
    cycle();
    cpuHALTACK = 1'b0;
  endtask

  task automatic pulse_cont();
    brCONT = 1'b1;
    cycle();
    brCONT = 1'b0;
  endtask

  initial begin
    bus.rst    = 1'b1;
    busVALID   = 1'b0;
    busADDR    = '0;
    brARM      = 1'b0;
    cpuHALTACK = 1'b0;
    brCONT     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.regBRAR[i] = '0;
      bus.regBRMR[i] = '0;
      brPASS[i]      = '0;
    end
    cycle();
    cycle();
    chk_all("reset", 2'd0, 1'b0, 4'b0000);
    bus.rst = 1'b0;

    // Unit 0, full mask, pass 0: halt two cycles after busVALID.
    bus.regBRMR[0] = '1;
    bus.regBRAR[0] = 36'o000000001000;
    pulse_arm();
    chk_all("arm0", 2'd1, 1'b0, 4'b0000);
    bus_cycle(36'o000000001000);
    chk_all("u0_lat1", 2'd1, 1'b0, 4'b0000);
    cycle();
    chk_all("u0_hit", 2'd2, 1'b1, 4'b1000);
    pulse_arm();
    chk_all("arm_in_haltreq", 2'd2, 1'b1, 4'b1000);
    pulse_ack();
    chk_all("u0_ack", 2'd3, 1'b0, 4'b1000);

    // Unit 1, pass 2: the third match halts.
    bus.regBRMR[0] = '0;
    bus.regBRMR[1] = '1;
    bus.regBRAR[1] = 36'o000000002000;
    brPASS[1] = 8'd2;
    pulse_arm();
    chk_all("arm1", 2'd1, 1'b0, 4'b0000);
    bus_cycle(36'o000000002000);
    cycle();
    bus_cycle(36'o000000002000);
    cycle();
    chk_all("u1_two_passes", 2'd1, 1'b0, 4'b0000);
    bus_cycle(36'o000000002000);
    cycle();
    chk_all("u1_third", 2'd2, 1'b1, 4'b0100);
    pulse_ack();

    // Unit 2, partial mask.
    bus.regBRMR[1] = '0;
    bus.regBRMR[2] = 36'o000000777000;
    bus.regBRAR[2] = 36'o000000123000;
    brPASS[1] = 8'd0;
    pulse_arm();
    bus_cycle(36'o000000124000);
    cycle();
    cycle();
    chk_all("u2_nomatch", 2'd1, 1'b0, 4'b0000);
    bus_cycle(36'o000000123456);
    cycle();
    chk_all("u2_match", 2'd2, 1'b1, 4'b0010);
    pulse_ack();

    // Units 0 and 3 hit together.
    bus.regBRMR[2] = '0;
    bus.regBRMR[0] = '1;
    bus.regBRAR[0] = 36'o000000005000;
    bus.regBRMR[3] = 36'o000000007000;
    bus.regBRAR[3] = 36'o000000005000;
    pulse_arm();
    bus_cycle(36'o000000005000);
    cycle();
    chk_all("u03_hit", 2'd2, 1'b1, 4'b1001);
    cycle();
    chk_all("u03_hold", 2'd2, 1'b1, 4'b1001);
    pulse_ack();
    chk_all("u03_halted", 2'd3, 1'b0, 4'b1001);
    pulse_cont();
    chk_all("u03_cont", 2'd1, 1'b0, 4'b0000);

    // brCONT zeroes counters: unit 0 loaded with 5 breaks at once after continue.
    brPASS[0] = 8'd5;
    pulse_arm();
    bus_cycle(36'o000000015000);
    cycle();
    chk_all("u3_only", 2'd2, 1'b1, 4'b0001);
    pulse_ack();
    pulse_cont();
    bus_cycle(36'o000000005000);
    cycle();
    chk_all("cont_cnt_zero", 2'd2, 1'b1, 4'b1001);

    // Reset while requesting halt.
    bus.rst = 1'b1;
    cycle();
    bus.rst = 1'b0;
    chk_all("rst_haltreq", 2'd0, 1'b0, 4'b0000);
    bus_cycle(36'o000000005000);
    cycle();
    cycle();
    chk_all("idle_ignores", 2'd0, 1'b0, 4'b0000);

    // brARM coincident with a registered match: match dropped, counters reloaded.
    bus.regBRMR[3] = '0;
    brPASS[0] = 8'd0;
    pulse_arm();
    brPASS[0] = 8'd1;
    busVALID = 1'b1;
    busADDR  = 36'o000000005000;
    cycle();
    busVALID = 1'b0;
    brARM = 1'b1;
    cycle();
    brARM = 1'b0;
    chk_all("arm_vs_match", 2'd1, 1'b0, 4'b0000);
    bus_cycle(36'o000000005000);
    cycle();
    chk_all("reload_pass1", 2'd1, 1'b0, 4'b0000);
    bus_cycle(36'o000000005000);
    cycle();
    chk_all("reload_hit", 2'd2, 1'b1, 4'b1000);
    pulse_ack();

    // brARM and brCONT together in HALTED: arm reloads pass 1.
    brARM  = 1'b1;
    brCONT = 1'b1;
    cycle();
    brARM  = 1'b0;
    brCONT = 1'b0;
    chk_all("arm_vs_cont", 2'd1, 1'b0, 4'b0000);
    bus_cycle(36'o000000005000);
    cycle();
    chk_all("arm_wins_cont", 2'd1, 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/br_ctrl.md
BR_CTRL -- requirements
Module: br_ctrl

Interface
REQ-001 Parameter: PASSW, 8, width of each breakpoint pass counter.
REQ-002 Parameter: NUNITS, 4, number of breakpoint units; fixed to match the 4 BRAR/BRMR register pairs.
REQ-003 clk  input  1  clock; the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 busVALID  input  1  one-cycle strobe marking a valid KS10 bus address cycle.
REQ-006 busADDR  input  [0:35]  bus address/flags word qualified by busVALID.
REQ-007 regBRAR  input  [0:35] x4  breakpoint address registers from the console.
REQ-008 regBRMR  input  [0:35] x4  breakpoint mask registers; mask bit 1 = compare this bit.
REQ-009 brARM  input  1  one-cycle console command: load pass counters and arm.
REQ-010 brPASS  input  [PASSW-1:0] x4  pass count per unit, sampled on brARM.
REQ-011 cpuHALTACK  input  1  CPU acknowledges the halt request.
REQ-012 brCONT  input  1  one-cycle console command: resume after a halt.
REQ-013 brHALT  output  1  halt request to the CPU.
REQ-014 brHIT  output  [0:3]  sticky per-unit hit flags.
REQ-015 brSTATE  output  2  current state encoding, for console status.

Function
REQ-016 A unit i SHALL be enabled iff regBRMR[i] != 0.
REQ-017 Match(i) SHALL be true iff busVALID and enabled(i) and (busADDR & regBRMR[i]) == (regBRAR[i] & regBRMR[i]); evaluate combinationally, register once (1-cycle latency).
REQ-018 States SHALL be IDLE(0), ARMED(1), HALTREQ(2), HALTED(3).
REQ-019 IDLE: brARM loads cnt[i] <= brPASS[i], clears brHIT, goes to ARMED; matches are ignored.
REQ-020 ARMED: on a registered match(i), if cnt[i] != 0 then cnt[i] decrements by 1, otherwise brHIT[i] is set.
REQ-021 ARMED: any newly set brHIT SHALL move the state to HALTREQ in the same edge; brHIT bits for units hitting together SHALL all be set.
REQ-022 Pass counters SHALL saturate at 0 and never wrap.
REQ-023 HALTREQ: brHALT = 1; matches ignored; cpuHALTACK moves the state to HALTED.
REQ-024 HALTED: brHALT = 0; brCONT returns to ARMED with brHIT cleared and counters at 0 (break on the next match); brARM reloads and goes to ARMED.
REQ-025 brARM in ARMED SHALL reload counters and clear brHIT; brARM in HALTREQ SHALL be ignored.
REQ-026 A simultaneous brARM and registered match in ARMED: brARM wins and the match is discarded.
REQ-027 A simultaneous brCONT and brARM in HALTED: brARM wins.
REQ-028 brHALT SHALL be a registered output, asserted the cycle after entering HALTREQ, and held until cpuHALTACK is sampled.

Reset
REQ-029 rst SHALL force: state IDLE, brHALT 0, brHIT 0, all cnt 0, match pipeline register 0, brSTATE 0.
REQ-030 rst asserted mid-HALTREQ SHALL drop brHALT on the next edge without waiting for cpuHALTACK.

Structure
REQ-031 The state enum, the state encodings and NUNITS SHALL live in a shared package brpkg.
REQ-032 The per-unit compare and pass counter SHALL be a sub-module br_unit, instantiated 4 times. br_ctrl holds the FSM and the halt handshake.
REQ-033 Console registers SHALL arrive through the existing br modport of the BR/CSL bus. regBRAR, regBRMR, clk and rst are taken from that modport.

Verification
REQ-034 Mask all-ones on unit 0, BRAR0=0o000000001000, pass=0, arm, then a bus cycle at 0o1000 -> brHIT=1000 and brHALT=1 two cycles after busVALID.
REQ-035 Pass=2 on unit 1, three matching cycles -> no halt after the first two; halt after the third.
REQ-036 Mask=0o000000777000 on unit 2, address 0o000000123456 against BRAR 0o000000123000 -> match; address 0o000000124000 -> no match.
REQ-037 Units 0 and 3 match the same cycle -> brHIT=1001, a single HALTREQ, ack -> HALTED, brCONT -> ARMED with brHIT=0000.
REQ-038 rst during HALTREQ -> brHALT=0 next cycle, state IDLE; a matching cycle afterwards -> no halt.
REQ-039 brARM coincident with a registered match -> brHIT stays 0000 and counters are reloaded to brPASS.
